gpu_cmd_fetch: RTL

Command-list DMA initiator that feeds the GPU core's control slave, so the CPU does not have to write every command word itself. The CPU programs a list base and length through a small CSR slave. The block reads {register address, data} entries from SDRAM over an Avalon read master and replays each one as an Avalon write into the GPU core's command port, honouring its wait_request back-pressure. A 4-entry prefetch FIFO lets SDRAM reads run ahead while the GPU stalls on raster or flush commands.

---
 rtl/gpu_cmd_fetch.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_fetch.sv
// gpu_cmd_fetch: command-list DMA initiator for the GPU core control slave.
// Reads {addr, data} entries from SDRAM over an Avalon read master, buffers
// them in a small show-ahead prefetch FIFO and replays each entry as an
// Avalon write on the GPU command port.
//
// Ports
//   clk, rst            single clock, asynchronous active-low reset
//   csr_*               CSR slave: 0 = BASE, 1 = LENGTH, 2 = CTRL/STATUS
//   rd_*                Avalon read master towards SDRAM (one read outstanding)
//   cmd_*               Avalon write master towards the GPU command port
//   irq                 level copy of the done bit
`timescale 1ns/1ps

module gpu_cmd_fetch #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [31:0] rd_address,
  output logic        rd_read,
  input  logic        rd_waitrequest,
  input  logic [31:0] rd_readdata,
  input  logic        rd_readdatavalid,
  output logic [7:0]  cmd_address,
  output logic        cmd_write,
  output logic [31:0] cmd_writedata,
  input  logic        cmd_waitrequest,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 40;

  typedef enum logic [2:0] {
    F_IDLE, F_HOLD, F_RD0, F_WT0, F_RD1, F_WT1, F_END
  } fetch_state_e;

  fetch_state_e    state;
  logic [31:0]     base_q;
  logic [15:0]     len_q;
  logic [15:0]     work_len;
  logic [15:0]     fetched;
  logic [15:0]     issued_count;
  logic [7:0]      entry_addr;
  logic            busy;
  logic            done;
  logic            aborting;

  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;

  logic            ctrl_wr;
  logic            start_acc;
  logic            abort_wr;
  logic            abort_now;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            slot_free;
  logic [CW-1:0]   count_after;
  logic            csr_read_unused;

  // The CSR slave has no wait states and readdata is a pure address decode.
  assign csr_read_unused = csr_read;

  assign ctrl_wr   = csr_write && (csr_address == 2'd2);
  assign start_acc = ctrl_wr && csr_writedata[0] && !busy;
  assign abort_wr  = ctrl_wr && csr_writedata[1] && busy;
  // Abort takes effect on the very cycle it is written, so no new read starts.
  assign abort_now = aborting || abort_wr;

  assign fifo_empty  = (fifo_count == '0);
  assign push        = (state == F_WT1) && rd_readdatavalid && !abort_now;
  assign pop         = cmd_write && !cmd_waitrequest;
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  // A new entry may only be fetched if it is guaranteed a slot on arrival.
  assign slot_free   = (count_after < CW'(FIFO_DEPTH));

  // Show-ahead issue side: the FIFO head drives the command port directly.
  assign cmd_write = !fifo_empty;
  assign {cmd_address, cmd_writedata} = fifo_mem[rd_ptr];
  assign irq = done;

  // CSR read decode.
  always_comb begin
    csr_readdata = '0;
    case (csr_address)
      2'd0:    csr_readdata = base_q;
      2'd1:    csr_readdata = {16'b0, len_q};
      2'd2:    csr_readdata = {busy, done, 14'b0, issued_count};
      default: csr_readdata = '0;
    endcase
  end

  // Programmable BASE / LENGTH registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
    end else begin
      if (csr_write && (csr_address == 2'd0)) base_q <= {csr_writedata[31:3], 3'b000};
      if (csr_write && (csr_address == 2'd1)) len_q  <= csr_writedata[15:0];
    end
  end

  // Prefetch FIFO and issued counter; an accepted write during abort flushes the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      issued_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[AW'(i)] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {entry_addr, rd_readdata};
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop && abort_now) begin
        rd_ptr     <= wr_ptr;
        fifo_count <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= count_after;
      end
      if (start_acc)  issued_count <= '0;
      else if (pop)   issued_count <= issued_count + 16'd1;
    end
  end

  // Fetch FSM with registered read-master outputs and busy/done status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= F_IDLE;
      rd_read    <= 1'b0;
      rd_address <= '0;
      work_len   <= '0;
      fetched    <= '0;
      entry_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborting   <= 1'b0;
    end else begin
      if (abort_wr) aborting <= 1'b1;
      case (state)
        F_IDLE: begin
          if (start_acc) begin
            work_len   <= len_q;
            fetched    <= '0;
            rd_address <= base_q;
            done       <= (len_q == '0);
            if (len_q != '0) begin
              busy    <= 1'b1;
              rd_read <= 1'b1;
              state   <= F_RD0;
            end
          end
        end
        F_HOLD: begin
          if (abort_now) begin
            state <= F_END;
          end else if (slot_free) begin
            rd_read <= 1'b1;
            state   <= F_RD0;
          end
        end
        F_RD0: begin
          if (!rd_waitrequest) begin
            rd_read    <= 1'b0;
            rd_address <= rd_address + 32'd4;
            state      <= F_WT0;
          end
        end
        F_WT0: begin
          if (rd_readdatavalid) begin
            if (abort_now || rd_readdata[31]) begin
              state <= F_END;
            end else begin
              entry_addr <= rd_readdata[7:0];
              rd_read    <= 1'b1;
              state      <= F_RD1;
            end
          end
        end
        F_RD1: begin
          if (!rd_waitrequest) begin
            rd_read    <= 1'b0;
            rd_address <= rd_address + 32'd4;
            state      <= F_WT1;
          end
        end
        F_WT1: begin
          if (rd_readdatavalid) begin
            if (abort_now) begin
              state <= F_END;
            end else begin
              fetched <= fetched + 16'd1;
              if ((fetched + 16'd1) == work_len) begin
                state <= F_END;
              end else if (slot_free) begin
                rd_read <= 1'b1;
                state   <= F_RD0;
              end else begin
                state <= F_HOLD;
              end
            end
          end
        end
        F_END: begin
          if (fifo_empty) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            aborting <= 1'b0;
            state    <= F_IDLE;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule
